// File: rtl/xpb_table_builder.sv
// Builds a table of residue multiples (i*B) mod M, one entry per cycle,
// streamed out through a registered write port to downstream lookup storage.
module xpb_table_builder #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wr_en,
  output logic [IDX_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]    wr_data
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_t              r_state;
  logic [WIDTH-1:0]    r_base;
  logic [WIDTH-1:0]    r_mod;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_wr_en;
  logic [IDX_BITS-1:0] r_wr_addr;
  logic [WIDTH-1:0]    r_wr_data;
  logic                w_accept;
  logic                w_reject;

  // One modular-add step; the sum keeps its carry bit so a + b >= 2^WIDTH
  // still compares correctly against m.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m})
      s = s - {1'b0, m};
    return s[WIDTH-1:0];
  endfunction

  assign w_accept = (r_state == IDLE) && start && (base < modulus);
  assign w_reject = (r_state == IDLE) && start && !(base < modulus);

  // Operand copies are pure data: loaded on accept, never reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_base <= base;
      r_mod  <= modulus;
    end
  end

  // wr_data doubles as the accumulator and wr_addr as the index, so the
  // outputs are registered without extra shadow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
          end else if (w_reject) begin
            r_err <= 1'b1;
          end
        end
        RUN: begin
          if (r_wr_addr == LAST_IDX) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b1;
          end else begin
            r_wr_addr <= r_wr_addr + 1'b1;
            r_wr_data <= mod_add(r_wr_data, r_base, r_mod);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_xpb_table_builder.sv
// Directed bench for xpb_table_builder: a narrow 8-bit/16-entry instance for
// hand-computed tables and a default 1024-bit instance against a wide-multiply model.
`timescale 1ns/1ps
module tb_xpb_table_builder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 8-bit, 16-entry instance
  logic       start8 = 1'b0;
  logic [7:0] base8 = '0, mod8 = '0;
  logic       busy8, done8, err8, wr_en8;
  logic [3:0] wr_addr8;
  logic [7:0] wr_data8;

  // default-parameter instance
  logic          start1k = 1'b0;
  logic [1023:0] base1k = '0, mod1k = '0;
  logic          busy1k, done1k, err1k, wr_en1k;
  logic [4:0]    wr_addr1k;
  logic [1023:0] wr_data1k;

  int checks = 0;
  int failures = 0;

  // (i*5) mod 13, i = 0..15
  logic [7:0] exp_tbl [16] = '{8'h0, 8'h5, 8'hA, 8'h2, 8'h7, 8'hC, 8'h4, 8'h9,
                              8'h1, 8'h6, 8'hB, 8'h3, 8'h8, 8'h0, 8'h5, 8'hA};

  xpb_table_builder #(.WIDTH(8), .IDX_BITS(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .base(base8), .modulus(mod8),
    .busy(busy8), .done(done8), .err(err8), .wr_en(wr_en8),
    .wr_addr(wr_addr8), .wr_data(wr_data8));

  xpb_table_builder dut1k (
    .clk(clk), .reset(reset), .start(start1k), .base(base1k), .modulus(mod1k),
    .busy(busy1k), .done(done1k), .err(err1k), .wr_en(wr_en1k),
    .wr_addr(wr_addr1k), .wr_data(wr_data1k));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err8); end
    checks++; if (wr_en8 !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en8); end
    checks++; if (wr_addr8 !== 4'h0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr8); end
    checks++; if (wr_data8 !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data8); end
    checks++; if (wr_en1k !== 1'b0 || busy1k !== 1'b0) begin failures++; $display("FAIL reset_1k wr_en=%b busy=%b exp=0,0", wr_en1k, busy1k); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_build_basic();
    base8 = 8'h05; mod8 = 8'h0D; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (wr_en8 !== 1'b1 || busy8 !== 1'b1 || done8 !== 1'b0) begin failures++; $display("FAIL basic_ctrl i=%0d wr_en=%b busy=%b done=%b exp=1,1,0", i, wr_en8, busy8, done8); end
      checks++; if (wr_addr8 !== 4'(i)) begin failures++; $display("FAIL basic_addr i=%0d got=%h exp=%h", i, wr_addr8, 4'(i)); end
      checks++; if (wr_data8 !== exp_tbl[i]) begin failures++; $display("FAIL basic_data i=%0d got=%h exp=%h", i, wr_data8, exp_tbl[i]); end
      tick();
    end
    checks++; if (done8 !== 1'b1 || busy8 !== 1'b0 || wr_en8 !== 1'b0) begin failures++; $display("FAIL basic_done done=%b busy=%b wr_en=%b exp=1,0,0", done8, busy8, wr_en8); end
    checks++; if (wr_addr8 !== 4'h0 || wr_data8 !== 8'h00) begin failures++; $display("FAIL basic_idle_zero addr=%h data=%h exp=0,00", wr_addr8, wr_data8); end
    tick();
    checks++; if (done8 !== 1'b0 || wr_en8 !== 1'b0) begin failures++; $display("FAIL basic_after done=%b wr_en=%b exp=0,0", done8, wr_en8); end
  endtask

  task automatic test_reject();
    logic [7:0] rb [3] = '{8'h0D, 8'hFF, 8'h05};
    logic [7:0] rm [3] = '{8'h0D, 8'hFF, 8'h00};
    for (int k = 0; k < 3; k++) begin
      base8 = rb[k]; mod8 = rm[k]; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      checks++; if (err8 !== 1'b1 || wr_en8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL reject_pulse k=%0d err=%b wr_en=%b busy=%b exp=1,0,0", k, err8, wr_en8, busy8); end
      tick();
      checks++; if (err8 !== 1'b0 || wr_en8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL reject_after k=%0d err=%b wr_en=%b busy=%b exp=0,0,0", k, err8, wr_en8, busy8); end
    end
  endtask

  // Carry path: B=FE, M=FF gives (i*254) mod 255 = 255-i for i>0.
  // Also disturbs start/base/modulus mid-build, which must be ignored.
  task automatic test_carry_and_ignore();
    logic [7:0] e;
    base8 = 8'hFE; mod8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e = (i == 0) ? 8'h00 : 8'(255 - i);
      checks++; if (wr_en8 !== 1'b1 || wr_addr8 !== 4'(i) || wr_data8 !== e) begin failures++; $display("FAIL carry_entry i=%0d wr_en=%b addr=%h data=%h exp=1,%h,%h", i, wr_en8, wr_addr8, wr_data8, 4'(i), e); end
      checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL carry_no_err i=%0d got=%b exp=0", i, err8); end
      if (i == 3) begin start8 = 1'b1; base8 = 8'hFF; mod8 = 8'h01; end
      if (i == 5) begin start8 = 1'b0; base8 = 8'h01; mod8 = 8'h02; end
      tick();
    end
    checks++; if (done8 !== 1'b1 || wr_en8 !== 1'b0) begin failures++; $display("FAIL carry_done done=%b wr_en=%b exp=1,0", done8, wr_en8); end
    tick();
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    base8 = 8'h05; mod8 = 8'h0D; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (5) tick();
    checks++; if (wr_en8 !== 1'b1 || wr_addr8 !== 4'h5) begin failures++; $display("FAIL abort_pre wr_en=%b addr=%h exp=1,5", wr_en8, wr_addr8); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (wr_en8 !== 1'b0 || busy8 !== 1'b0 || wr_addr8 !== 4'h0 || wr_data8 !== 8'h00) begin failures++; $display("FAIL abort_cut wr_en=%b busy=%b addr=%h data=%h exp=0,0,0,00", wr_en8, busy8, wr_addr8, wr_data8); end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done8 === 1'b1 || wr_en8 === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_quiet got=%b exp=0", saw_done); end
    base8 = 8'h05; mod8 = 8'h0D; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (wr_en8 !== 1'b1 || wr_addr8 !== 4'(i) || wr_data8 !== exp_tbl[i]) begin failures++; $display("FAIL rebuild i=%0d wr_en=%b addr=%h data=%h exp=1,%h,%h", i, wr_en8, wr_addr8, wr_data8, 4'(i), exp_tbl[i]); end
      tick();
    end
    checks++; if (done8 !== 1'b1) begin failures++; $display("FAIL rebuild_done got=%b exp=1", done8); end
    tick();
  endtask

  task automatic test_back_to_back();
    base8 = 8'h05; mod8 = 8'h0D; start8 = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (wr_en8 !== 1'b1 || wr_addr8 !== 4'(i) || wr_data8 !== exp_tbl[i]) begin failures++; $display("FAIL b2b b=%0d i=%0d wr_en=%b addr=%h data=%h exp=1,%h,%h", b, i, wr_en8, wr_addr8, wr_data8, 4'(i), exp_tbl[i]); end
        tick();
      end
      checks++; if (done8 !== 1'b1 || wr_en8 !== 1'b0 || busy8 !== 1'b0 || err8 !== 1'b0) begin failures++; $display("FAIL b2b_gap b=%0d done=%b wr_en=%b busy=%b err=%b exp=1,0,0,0", b, done8, wr_en8, busy8, err8); end
      if (b == 1) start8 = 1'b0;
      tick();
    end
    checks++; if (wr_en8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL b2b_stop wr_en=%b busy=%b exp=0,0", wr_en8, busy8); end
  endtask

  task automatic test_default_width();
    logic [1023:0] bs, ms, e;
    logic [1029:0] prod;
    for (int k = 0; k < 32; k++) begin
      mod1k[k*32 +: 32]  = $urandom;
      base1k[k*32 +: 32] = $urandom;
    end
    mod1k[1023] = 1'b1;
    base1k[1023] = 1'b0;
    bs = base1k; ms = mod1k;
    start1k = 1'b1;
    tick();
    start1k = 1'b0;
    for (int i = 0; i < 32; i++) begin
      prod = 1030'(i) * {6'b0, bs};
      prod = prod % {6'b0, ms};
      e = prod[1023:0];
      checks++; if (wr_en1k !== 1'b1 || wr_addr1k !== 5'(i) || err1k !== 1'b0) begin failures++; $display("FAIL wide_ctrl i=%0d wr_en=%b addr=%h err=%b exp=1,%h,0", i, wr_en1k, wr_addr1k, err1k, 5'(i)); end
      checks++; if (wr_data1k !== e) begin failures++; $display("FAIL wide_data i=%0d got_lo=%h exp_lo=%h", i, wr_data1k[63:0], e[63:0]); end
      if (i == 5 || i == 20) begin start1k = 1'b1; base1k = ~base1k; mod1k = mod1k >> 3; end
      if (i == 6 || i == 21) start1k = 1'b0;
      tick();
    end
    checks++; if (done1k !== 1'b1 || wr_en1k !== 1'b0 || busy1k !== 1'b0) begin failures++; $display("FAIL wide_done done=%b wr_en=%b busy=%b exp=1,0,0", done1k, wr_en1k, busy1k); end
    tick();
  endtask

  initial begin
    test_reset();
    test_build_basic();
    test_reject();
    test_carry_and_ignore();
    test_reset_abort();
    test_back_to_back();
    test_default_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xpb_table_builder.md
XPB_TABLE_BUILDER -- requirements
Module: xpb_table_builder

Interface
REQ-001 Parameter WIDTH, default 1024: bit width of base, modulus and table entries.
REQ-002 Parameter IDX_BITS, default 5: index width; table depth is 2^IDX_BITS entries.
REQ-003 clk  input  1  sole clock; all logic rises on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to build one table; sampled only in IDLE.
REQ-006 base  input  WIDTH  value B whose residue multiples form the table; sampled with start.
REQ-007 modulus  input  WIDTH  modulus M; sampled with start.
REQ-008 busy  output  1  high while a build is in progress.
REQ-009 done  output  1  one-cycle pulse after the last entry is written.
REQ-010 err  output  1  one-cycle pulse when start is rejected.
REQ-011 wr_en  output  1  table write strobe to the downstream lookup storage.
REQ-012 wr_addr  output  IDX_BITS  table index being written.
REQ-013 wr_data  output  WIDTH  entry value: (wr_addr * B) mod M.

Function
REQ-014 States SHALL be IDLE and RUN only.
REQ-015 In IDLE, start=1 with base < modulus SHALL latch base and modulus, clear accumulator and index, and enter RUN next cycle.
REQ-016 In IDLE, start=1 with base >= modulus (includes modulus=0) SHALL pulse err for exactly one cycle, generate no writes, and remain in IDLE.
REQ-017 With start sampled in cycle T, wr_en SHALL be high in cycles T+1 through T+2^IDX_BITS inclusive, with no gaps.
REQ-018 In cycle T+1+i, wr_addr SHALL equal i and wr_data SHALL equal (i*B) mod M, for i = 0 .. 2^IDX_BITS-1; entry 0 SHALL be 0.
REQ-019 Accumulator update per written entry: s = acc + B, computed at WIDTH+1 bits; acc_next = s - M if s >= M, else s; no truncation of the carry bit before the compare.
REQ-020 wr_addr SHALL wrap from 2^IDX_BITS-1 to 0 only on entry to RUN; RUN SHALL exit after the entry at the last index is written.
REQ-021 busy SHALL be high in cycles T+1 .. T+2^IDX_BITS and low otherwise.
REQ-022 done SHALL pulse high in cycle T+2^IDX_BITS+1 only, with busy low in that cycle; the FSM SHALL be back in IDLE in that cycle.
REQ-023 start asserted while in RUN SHALL be ignored, with no err and no effect on the build in progress.
REQ-024 start asserted in the done cycle SHALL be accepted, because IDLE is already active; the next build's writes SHALL begin in the following cycle.
REQ-025 Changes on base and modulus while in RUN SHALL have no effect; only the latched copies are used.
REQ-026 When wr_en=0, wr_addr and wr_data SHALL be driven to 0.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 reset=1 SHALL force the following at the next edge: IDLE; busy, done, err and wr_en all 0; wr_addr, wr_data, accumulator and index all 0.
REQ-029 reset asserted during RUN SHALL abort the build; wr_en SHALL be 0 from the following cycle, and no done pulse SHALL occur.
REQ-030 reset SHALL take priority over start in the same cycle.

Verification
REQ-031 WIDTH=8, IDX_BITS=4, B=0x05, M=0x0D, start in cycle T -> writes in cycles T+1..T+16 with data 0,5,A,2,7,C,4,9,1,6,B,3,8,0,5,A at addr 0..F; done pulse at T+17.
REQ-032 WIDTH=8, B=0x0D, M=0x0D -> err pulse in cycle T+1; no wr_en; busy stays 0.
REQ-033 WIDTH=8, B=0xFF, M=0xFF is rejected; B=0xFE, M=0xFF -> entry 2 = 0xFD; this exercises the carry bit in REQ-019.
REQ-034 Default parameters with a random 1024-bit M and B < M -> all 32 entries match a golden model of i*B mod M; start pulses during RUN cause no disturbance.
REQ-035 reset asserted in cycle T+6 of a build -> wr_en low from T+7, no done pulse; a fresh start afterwards rebuilds from entry 0 correctly.
REQ-036 start held high continuously -> back-to-back builds, each with 2^IDX_BITS writes separated by exactly one idle (done) cycle.
